// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning logic.
package button_pkg;

   localparam int unsigned CLOCK_HZ      = 12_000_000;
   localparam int unsigned DEBOUNCE_10MS = CLOCK_HZ / 100;
   localparam int unsigned LONG_PRESS_1S = CLOCK_HZ;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop single-bit synchronizer with an asynchronous reset value.
module sync_chain #(
   parameter int unsigned STAGES      = 2,
   parameter bit          RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         chain_q <= {STAGES{RESET_VALUE}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a push-button, emitting press/release/long-press
// pulses and a sticky shift bit that survives until the next shift strobe.
module button_debouncer
   import button_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
   parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_1S,
   parameter bit          ACTIVE_LOW        = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button_raw,
   input  logic consume,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic shift_bit
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned LP_W  = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LP_W-1:0]  LP_MAX  = LP_W'(LONG_PRESS_CYCLES - 1);

   logic pin;
   logic s;

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LP_W-1:0]  lp_cnt_q, lp_cnt_d;
   logic             lp_fired_q, lp_fired_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;
   logic             pending_q, pending_d;

   assign pin = ACTIVE_LOW ? ~button_raw : button_raw;

   sync_chain #(
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (1'b0)
   ) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (pin),
      .q       (s)
   );

   // Debounce FSM next state, counters and output pulses.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lp_cnt_d   = lp_cnt_q;
      lp_fired_d = lp_fired_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      case (state_q)
         RELEASED: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_MAX) begin
               state_d    = PRESSED;
               press_d    = 1'b1;
               level_d    = 1'b1;
               lp_cnt_d   = '0;
               lp_fired_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (lp_cnt_q == LP_MAX) begin
               // Counter parks at its maximum; the flag keeps the pulse single.
               if (!lp_fired_q) begin
                  long_d     = 1'b1;
                  lp_fired_d = 1'b1;
               end
            end else begin
               lp_cnt_d = lp_cnt_q + LP_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = RELEASED;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = RELEASED;
      endcase
      // A new press wins over a simultaneous strobe so it is not lost.
      pending_d = press_d | (pending_q & ~consume);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RELEASED;
         cnt_q      <= '0;
         lp_cnt_q   <= '0;
         lp_fired_q <= 1'b0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lp_cnt_q   <= lp_cnt_d;
         lp_fired_q <= lp_fired_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         pending_q  <= pending_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign shift_bit     = pending_q | level_q;

endmodule
